// File: rtl/bit_scan_encoder_pkg.sv
// rtl/bit_scan_encoder_pkg.sv - shared scan-order constants and FSM state type
package bit_scan_encoder_pkg;

  localparam int SCAN_LSB_FIRST = 0;
  localparam int SCAN_MSB_FIRST = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/bit_scan_encoder_ffs_find.sv
// rtl/bit_scan_encoder_ffs_find.sv - combinational find-first-set with one-hot detect
module ffs_find
  import bit_scan_encoder_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter int  MSB_FIRST = SCAN_LSB_FIRST,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             single
);

  logic [WIDTH-1:0] w_low_cleared;

  // The last match written wins, so iterate away from the preferred end.
  always_comb begin
    idx = '0;
    if (MSB_FIRST == SCAN_MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

  assign w_low_cleared = vec & (vec - WIDTH'(1));
  assign any           = |vec;
  assign single        = any && (w_low_cleared == '0);

endmodule

// File: rtl/bit_scan_encoder.sv
// rtl/bit_scan_encoder.sv - streams the index of every set request bit, one per beat
module bit_scan_encoder
  import bit_scan_encoder_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter int  MSB_FIRST = SCAN_LSB_FIRST,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] w_pend_nxt;
  logic             r_zero_f;
  logic             w_zero_nxt;

  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_single;
  logic             w_accept;
  logic             w_beat;
  logic [WIDTH-1:0] w_clr_mask;

  ffs_find #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_ffs (
    .vec    (r_pend),
    .idx    (w_idx),
    .any    (w_any),
    .single (w_single)
  );

  assign out_valid  = (r_state == ST_SCAN);
  assign out_idx    = r_zero_f ? '0 : w_idx;
  assign out_last   = w_single || r_zero_f;
  assign out_zero   = r_zero_f;

  // out_ready feeds in_ready directly so a new vector can load on the last beat.
  assign in_ready   = (r_state == ST_IDLE) || (out_valid && out_ready && out_last);
  assign w_accept   = in_valid && in_ready;
  assign w_beat     = out_valid && out_ready;
  assign w_clr_mask = WIDTH'(1) << w_idx;

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_zero_nxt  = r_zero_f;
    if (w_accept) begin
      w_state_nxt = ST_SCAN;
      w_pend_nxt  = in_vec;
      w_zero_nxt  = (in_vec == '0);
    end else if (w_beat) begin
      if (out_last) begin
        // Clearing on exit keeps idle outputs at their reset values.
        w_state_nxt = ST_IDLE;
        w_pend_nxt  = '0;
        w_zero_nxt  = 1'b0;
      end else if (w_any) begin
        w_pend_nxt  = r_pend & ~w_clr_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_pend   <= '0;
      r_zero_f <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pend   <= w_pend_nxt;
      r_zero_f <= w_zero_nxt;
    end
  end

endmodule

// File: tb/tb_bit_scan_encoder.sv
// tb/tb_bit_scan_encoder.sv - directed table and sequence checks for bit_scan_encoder
module tb_bit_scan_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_vec;
  logic [4:0] in_vec5;

  logic       m_in_ready, m_out_valid, m_out_last, m_out_zero;
  logic [2:0] m_out_idx;
  logic       s_in_ready, s_out_valid, s_out_last, s_out_zero;
  logic [2:0] s_out_idx;
  logic       f_in_ready, f_out_valid, f_out_last, f_out_zero;
  logic [2:0] f_out_idx;

  int total = 0;
  int bad   = 0;

  int q_m[$], q_ml[$], q_mz[$], q_s[$], q_f[$], q_fl[$];
  int m_first;

  always #5 clk = ~clk;

  bit_scan_encoder #(.WIDTH(8), .MSB_FIRST(0)) u_main (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready), .in_vec(in_vec),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_idx(m_out_idx),
    .out_last(m_out_last), .out_zero(m_out_zero));

  bit_scan_encoder #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_vec(in_vec),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_idx(s_out_idx),
    .out_last(s_out_last), .out_zero(s_out_zero));

  bit_scan_encoder #(.WIDTH(5), .MSB_FIRST(0)) u_w5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(f_in_ready), .in_vec(in_vec5),
    .out_valid(f_out_valid), .out_ready(out_ready), .out_idx(f_out_idx),
    .out_last(f_out_last), .out_zero(f_out_zero));

  // beats: beat k expected index is hex digit k (lowest digit first)
  typedef struct {
    logic [7:0] vec;
    int         n;
    logic [31:0] beats;
    int         zero;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(m_in_ready && s_in_ready && f_in_ready && !m_out_valid) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("idle_timeout", 0, 1);
  endtask

  task automatic pulse_collect(input logic [7:0] v8, input logic [4:0] v5);
    q_m.delete(); q_ml.delete(); q_mz.delete(); q_s.delete(); q_f.delete(); q_fl.delete();
    m_first = -1;
    wait_idle();
    in_vec = v8; in_vec5 = v5; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (m_out_valid) begin
        if (m_first < 0) m_first = c;
        q_m.push_back(int'(m_out_idx)); q_ml.push_back(int'(m_out_last));
        q_mz.push_back(int'(m_out_zero));
      end
      if (s_out_valid) q_s.push_back(int'(s_out_idx));
      if (f_out_valid) begin
        q_f.push_back(int'(f_out_idx)); q_fl.push_back(int'(f_out_last));
      end
    end
  endtask

  initial begin
    tbl[0] = '{8'b0000_0100, 1, 32'h2,        0};
    tbl[1] = '{8'b1001_0010, 3, 32'h741,      0};
    tbl[2] = '{8'b0000_0000, 1, 32'h0,        1};
    tbl[3] = '{8'b1111_1111, 8, 32'h76543210, 0};
    tbl[4] = '{8'b1000_0000, 1, 32'h7,        0};
    tbl[5] = '{8'b0000_0001, 1, 32'h0,        0};
    tbl[6] = '{8'b0101_1010, 4, 32'h6431,     0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0; in_vec5 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(m_out_valid), 0);
    chk("rst_in_ready",  int'(m_in_ready), 1);
    chk("rst_out_idx",   int'(m_out_idx), 0);
    chk("rst_out_last",  int'(m_out_last), 0);
    chk("rst_out_zero",  int'(m_out_zero), 0);

    for (int t = 0; t < 7; t++) begin
      pulse_collect(tbl[t].vec, 5'd0);
      chk($sformatf("t%0d_latency", t), m_first, 0);
      chk($sformatf("t%0d_beats", t), q_m.size(), tbl[t].n);
      chk($sformatf("t%0d_msb_beats", t), q_s.size(), tbl[t].n);
      for (int k = 0; k < tbl[t].n; k++) begin
        if (k < q_m.size()) begin
          chk($sformatf("t%0d_idx%0d", t, k), q_m[k], int'((tbl[t].beats >> (4 * k)) & 7));
          chk($sformatf("t%0d_last%0d", t, k), q_ml[k], (k == tbl[t].n - 1) ? 1 : 0);
          chk($sformatf("t%0d_zero%0d", t, k), q_mz[k], tbl[t].zero);
        end
        if (k < q_s.size())
          chk($sformatf("t%0d_msb_idx%0d", t, k), q_s[k],
              int'((tbl[t].beats >> (4 * (tbl[t].n - 1 - k))) & 7));
      end
    end

    pulse_collect(8'h00, 5'b10001);
    chk("w5_beats", q_f.size(), 2);
    if (q_f.size() == 2) begin
      chk("w5_idx0", q_f[0], 0); chk("w5_last0", q_fl[0], 0);
      chk("w5_idx1", q_f[1], 4); chk("w5_last1", q_fl[1], 1);
    end
    pulse_collect(8'h00, 5'b11111);
    chk("w5_full_beats", q_f.size(), 5);
    for (int k = 0; k < q_f.size(); k++) chk($sformatf("w5_full_idx%0d", k), q_f[k], k);

    // stall holds the head beat and blocks new input
    wait_idle();
    in_vec = 8'b0000_0011; in_vec5 = '0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", c), int'(m_out_valid), 1);
      chk($sformatf("stall%0d_idx", c), int'(m_out_idx), 0);
      chk($sformatf("stall%0d_last", c), int'(m_out_last), 0);
      chk($sformatf("stall%0d_in_ready", c), int'(m_in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_beat1_valid", int'(m_out_valid), 1);
    chk("stall_beat1_idx", int'(m_out_idx), 1);
    chk("stall_beat1_last", int'(m_out_last), 1);
    @(negedge clk);
    chk("stall_done_valid", int'(m_out_valid), 0);

    // back-to-back: second vector loads on the last beat of the first
    wait_idle();
    in_vec = 8'h81; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_vec = 8'h08;
    @(negedge clk);
    chk("b2b_beat0_idx", int'(m_out_idx), 0);
    chk("b2b_beat0_valid", int'(m_out_valid), 1);
    chk("b2b_beat0_in_ready", int'(m_in_ready), 0);
    @(negedge clk);
    chk("b2b_beat1_idx", int'(m_out_idx), 7);
    chk("b2b_beat1_last", int'(m_out_last), 1);
    chk("b2b_beat1_in_ready", int'(m_in_ready), 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_beat2_valid", int'(m_out_valid), 1);
    chk("b2b_beat2_idx", int'(m_out_idx), 3);
    chk("b2b_beat2_last", int'(m_out_last), 1);
    @(negedge clk);
    chk("b2b_done_valid", int'(m_out_valid), 0);

    // reset in the middle of a scan drops the rest of the vector
    wait_idle();
    in_vec = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_pre_valid", int'(m_out_valid), 1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", int'(m_out_valid), 0);
    chk("mid_rst_in_ready", int'(m_in_ready), 1);
    chk("mid_rst_msb_valid", int'(s_out_valid), 0);
    @(negedge clk);
    chk("mid_rst_stays_idle", int'(m_out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
